// File: rtl/kh_rf_pkg.sv
// Shared widths, types and helpers for the KH32 scoreboarded register file.
package kh_rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREG       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when the address names the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr, input logic r0_zero);
        return r0_zero && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/kh_rf_read_port.sv
// One unregistered read port: 32:1 select, r0 forcing and, when
// KH_RF_BYPASS_EN is defined, forwarding of the same-cycle write-back.
module kh_rf_read_port
    import kh_rf_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREG    = 32,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic [NREG-1:0][DATA_W-1:0] regs,
    input  logic [REG_ADDR_W-1:0]       addr,
`ifdef KH_RF_BYPASS_EN
    input  logic                        wb_valid,
    input  logic [REG_ADDR_W-1:0]       wb_rd,
    input  logic [DATA_W-1:0]           wb_data,
`endif
    output logic [DATA_W-1:0]           operand_c
);

    // Array select, then forwarding, then r0 override (r0 is never forwarded).
    always_comb begin
        operand_c = regs[addr];
`ifdef KH_RF_BYPASS_EN
        if (wb_valid && (wb_rd == addr)) begin
            operand_c = wb_data;
        end
`endif
        if (is_zero_reg(addr, R0_ZERO)) begin
            operand_c = '0;
        end
    end

endmodule

// File: rtl/kh_regfile_sb.sv
// KH32 scoreboarded register file: architectural state, write-back,
// in-flight destination tracking, RAW/WAW issue gating and registered
// operand return. Define KH_RF_BYPASS_EN to let a same-cycle write-back
// resolve a hazard and forward its data into the captured operand.
module kh_regfile_sb
    import kh_rf_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREG    = 32,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    output logic                  op_valid,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [NREG-1:0]       busy,
    output logic                  err_wb
);

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             busy_eff_c;
    logic [NREG-1:0]             busy_nxt_c;
    logic [DATA_W-1:0]           op1_c;
    logic [DATA_W-1:0]           op2_c;
    logic                        accept_c;
    logic                        set_rd_c;
    logic                        wb_write_c;

    // Pending view used for hazard detection; r0 never hazards.
    always_comb begin
        busy_eff_c = busy;
`ifdef KH_RF_BYPASS_EN
        if (wb_valid) begin
            busy_eff_c[wb_rd] = 1'b0;
        end
`endif
        if (R0_ZERO) begin
            busy_eff_c[REG_ZERO] = 1'b0;
        end
    end

    // Issue gating on RAW (rs1/rs2) and WAW (rd) hazards.
    always_comb begin
        issue_ready = !(busy_eff_c[issue_rs1] || busy_eff_c[issue_rs2] ||
                        (issue_rd_we && busy_eff_c[issue_rd]));
        accept_c    = issue_valid && issue_ready;
        set_rd_c    = accept_c && issue_rd_we && !is_zero_reg(issue_rd, R0_ZERO);
        wb_write_c  = wb_valid && !is_zero_reg(wb_rd, R0_ZERO);
    end

    // Scoreboard next state: write-back clears first so a same-cycle set wins.
    always_comb begin
        busy_nxt_c = busy;
        if (wb_valid) begin
            busy_nxt_c[wb_rd] = 1'b0;
        end
        if (set_rd_c) begin
            busy_nxt_c[issue_rd] = 1'b1;
        end
    end

    kh_rf_read_port #(
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .R0_ZERO (R0_ZERO)
    ) u_rp1 (
        .regs      (regs),
        .addr      (issue_rs1),
`ifdef KH_RF_BYPASS_EN
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`endif
        .operand_c (op1_c)
    );

    kh_rf_read_port #(
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .R0_ZERO (R0_ZERO)
    ) u_rp2 (
        .regs      (regs),
        .addr      (issue_rs2),
`ifdef KH_RF_BYPASS_EN
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`endif
        .operand_c (op2_c)
    );

    // Register array write-back; a reset-cycle write-back is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wb_write_c) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard and sticky unexpected-write-back flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= '0;
            err_wb <= 1'b0;
        end else begin
            busy <= busy_nxt_c;
            if (wb_valid && !busy[wb_rd]) begin
                err_wb <= 1'b1;
            end
        end
    end

    // Operand capture and one-cycle valid pulse per accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            op_valid <= accept_c;
            if (accept_c) begin
                rs1_data <= op1_c;
                rs2_data <= op2_c;
            end
        end
    end

endmodule

// File: tb/tb_kh_regfile_sb.sv
// Scoreboard bench for kh_regfile_sb: directed cases then randomized issue
// and write-back traffic against a behavioural register-file model.
module tb_kh_regfile_sb;
    import kh_rf_pkg::*;

`ifdef KH_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic        issue_rd_we = 1'b0;
    logic        op_valid;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] busy;
    logic        err_wb;

    kh_regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .op_valid(op_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .err_wb(err_wb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] m_mem [32];
    logic [31:0] m_busy = '0;
    logic        m_err = 1'b0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        int          due;
    } exp_t;
    exp_t q[$];

    int  n_chk = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // A register is a hazard when pending, not r0, and not being written back in a bypass build.
    function automatic bit m_pend(input logic [4:0] a);
        return m_busy[a] && (a != 5'd0) && !(BYP && wb_valid && (wb_rd == a));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && wb_valid && (wb_rd == a)) return wb_data;
        return m_mem[a];
    endfunction

    // One clock of stimulus; returns whether the model accepted the request.
    task automatic step(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit we, input bit wv,
                        input logic [4:0] wrd, input logic [31:0] wd,
                        input bit rn, output bit acc);
        bit mr;
        @(negedge clk);
        issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd; issue_rd_we = we;
        wb_valid = wv; wb_rd = wrd; wb_data = wd; rst_n = rn;
        #1;
        mr = !(m_pend(r1) || m_pend(r2) || (we && m_pend(rd)));
        if (mon_en) check("issue_ready", 64'(issue_ready), 64'(mr));
        acc = rn && v && mr;
        if (acc) q.push_back('{d1: m_read(r1), d2: m_read(r2), due: cyc + 1});
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            if (wv) begin
                if (!m_busy[wrd]) m_err = 1'b1;
                m_busy[wrd] = 1'b0;
                if (wrd != 5'd0) m_mem[wrd] = wd;
            end
            if (acc && we && (rd != 5'd0)) m_busy[rd] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    endtask

    // Monitor: compares registered state every cycle and pops on op_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 64'(busy), 64'(m_busy));
                check("err_wb", 64'(err_wb), 64'(m_err));
                if (op_valid) begin
                    if (q.size() == 0) begin
                        check("op_valid_unexpected", 64'(op_valid), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("op_latency", 64'(cyc), 64'(e.due));
                        check("rs1_data", 64'(rs1_data), 64'(e.d1));
                        check("rs2_data", 64'(rs2_data), 64'(e.d2));
                    end
                end else if (q.size() != 0 && q[0].due <= cyc) begin
                    check("op_valid_missing", 64'(op_valid), 64'(1));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        bit acc;
        bit have;
        logic [4:0] p1, p2, prd, wr;
        bit pwe, wv;
        int s;

        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        mon_en = 1'b1;

        // Basic read after reset
        step(1, 3, 0, 0, 0, 0, 0, 0, 1, acc);
        idle(1);
        // Unexpected write-back, then read it
        step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, acc);
        #1 check("err_after_wb5", 64'(err_wb), 64'(1));
        step(1, 5, 0, 0, 0, 0, 0, 0, 1, acc);
        idle(1);
        // RAW on r7 resolved by write-back (same cycle with bypass, next cycle without)
        step(1, 1, 2, 7, 1, 0, 0, 0, 1, acc);
        step(1, 0, 7, 0, 0, 1, 7, 32'h1234, 1, acc);
        if (!acc) step(1, 0, 7, 0, 0, 0, 0, 0, 1, acc);
        idle(1);
        // Same-cycle clear and set on r9: set wins
        step(1, 0, 0, 9, 1, 1, 9, 32'h99, 1, acc);
        #1 check("busy9_set_wins", 64'(busy[9]), 64'(1));
        step(0, 0, 0, 0, 0, 1, 9, 32'h55, 1, acc);
        // r0 destination never pending; write to r0 dropped
        step(1, 0, 0, 0, 1, 0, 0, 0, 1, acc);
        #1 check("busy0_never", 64'(busy[0]), 64'(0));
        step(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, acc);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, acc);
        idle(1);
        // Reset mid-operation with a write-back on pending r4
        step(1, 0, 0, 4, 1, 0, 0, 0, 1, acc);
        step(0, 0, 0, 0, 0, 1, 4, 32'hCAFE0004, 0, acc);
        #1 check("busy_after_rst", 64'(busy), 64'(0));
        step(1, 4, 4, 0, 0, 0, 0, 0, 1, acc);
        idle(1);

        // Randomized traffic; stalled requests hold their fields.
        have = 1'b0;
        p1 = '0; p2 = '0; prd = '0; pwe = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!have && ($urandom_range(3) != 0)) begin
                have = 1'b1;
                p1 = 5'($urandom_range(31));
                p2 = 5'($urandom_range(31));
                prd = 5'($urandom_range(31));
                pwe = ($urandom_range(2) != 0);
            end
            wv = ($urandom_range(1) == 1);
            wr = 5'($urandom_range(31));
            if (wv && ($urandom_range(3) != 0)) begin
                s = $urandom_range(31);
                for (int i = 0; i < 32; i++) begin
                    if (m_busy[(s + i) % 32]) begin
                        wr = 5'((s + i) % 32);
                        break;
                    end
                end
            end
            step(have, p1, p2, prd, pwe, wv, wr, $urandom, ($urandom_range(199) != 0), acc);
            if (acc) have = 1'b0;
        end
        idle(4);
        check("queue_drain", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
